morse_capture_sequencer: RTL

// Controller for the Morse character capture block. Derives its four timing thresholds from one

---
 rtl/morse_capture_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/morse_capture_sequencer.sv
// morse_capture_sequencer
// Sequences one Morse capture block: derives its timing thresholds from a
// single unit time, issues the start pulse, turns char/word-end events into
// FIFO entries and re-arms the capture block after every word gap. Entries
// are drained by the downstream decoder over a valid/ready stream.
module morse_capture_sequencer #(
  parameter int PULSE_CNT_W   = 16,
  parameter int MORSE_LEN_W   = 3,
  parameter int MAX_MORSE_LEN = 6,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [PULSE_CNT_W-1:0]   unit_time,
  input  logic                     signal,
  output logic                     cap_start,
  output logic [PULSE_CNT_W-1:0]   cap_dit_time,
  output logic [PULSE_CNT_W-1:0]   cap_dah_time,
  output logic [PULSE_CNT_W-1:0]   cap_word_time,
  output logic [PULSE_CNT_W-1:0]   cap_tol_time,
  input  logic [MORSE_LEN_W-1:0]   cap_len,
  input  logic [MAX_MORSE_LEN-1:0] cap_dits_dahs,
  input  logic                     cap_error,
  input  logic                     cap_char_end,
  input  logic                     cap_word_end,
  input  logic                     cap_ceo,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MORSE_LEN_W-1:0]   out_len,
  output logic [MAX_MORSE_LEN-1:0] out_dits_dahs,
  output logic                     out_word,
  output logic                     out_error,
  output logic                     busy,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int ENTRY_W = MORSE_LEN_W + MAX_MORSE_LEN + 2;
  localparam int PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CONFIG  = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;

  // FSM state
  logic [2:0]             state_reg, state_next;
  logic                   char_seen_reg, char_seen_next;
  logic                   word_seen_reg, word_seen_next;
  logic                   char_end_d_reg;
  logic [PULSE_CNT_W-1:0] rec_cnt_reg, rec_cnt_next;
  logic [PULSE_CNT_W:0]   rec_cnt_inc;
  logic                   cfg_load;
  logic                   push_req;
  logic [ENTRY_W-1:0]     push_entry;
  logic                   char_rise, word_rise;

  // Thresholds
  logic [PULSE_CNT_W-1:0] unit_sel;
  logic [PULSE_CNT_W+2:0] dah_wide, word_wide;
  logic [PULSE_CNT_W-1:0] dah_sat, word_sat;
  logic [PULSE_CNT_W-1:0] dit_time_reg, dah_time_reg, word_time_reg, tol_time_reg;

  // FIFO
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               overflow_reg;
  logic [7:0]         drop_cnt_reg;
  logic               push, push_ok, pop, fifo_full;
  logic [ENTRY_W-1:0] head_entry;

  // A zero unit time would collapse every threshold, so it is promoted to 1.
  // The products are formed three bits wider so overflow is visible.
  assign unit_sel  = (unit_time == '0) ? PULSE_CNT_W'(1) : unit_time;
  assign dah_wide  = {3'b000, unit_sel} + {2'b00, unit_sel, 1'b0};
  assign word_wide = {unit_sel, 3'b000} - {3'b000, unit_sel};
  assign dah_sat   = (|dah_wide[PULSE_CNT_W+2:PULSE_CNT_W])  ? '1 : dah_wide[PULSE_CNT_W-1:0];
  assign word_sat  = (|word_wide[PULSE_CNT_W+2:PULSE_CNT_W]) ? '1 : word_wide[PULSE_CNT_W-1:0];

  assign char_rise   = cap_char_end & ~char_seen_reg;
  assign word_rise   = cap_word_end & ~word_seen_reg;
  assign rec_cnt_inc = {1'b0, rec_cnt_reg} + (PULSE_CNT_W + 1)'(1);

  // Next-state, entry generation and recovery counting, applied on ce
  always_comb begin
    state_next     = state_reg;
    char_seen_next = char_seen_reg;
    word_seen_next = word_seen_reg;
    rec_cnt_next   = rec_cnt_reg;
    cfg_load       = 1'b0;
    push_req       = 1'b0;
    push_entry     = '0;
    if (!enable) begin
      // Leaving a session discards whatever event is on the inputs right now.
      state_next   = ST_IDLE;
      rec_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE:   state_next = ST_CONFIG;
        ST_CONFIG: begin
          cfg_load   = 1'b1;
          state_next = ST_ARM;
        end
        ST_ARM: begin
          if (!signal) state_next = ST_START;
        end
        ST_START: begin
          char_seen_next = 1'b0;
          word_seen_next = 1'b0;
          state_next     = ST_RUN;
        end
        ST_RUN: begin
          // A falling char_end means a new key-down: the next char_end is fresh.
          if (char_end_d_reg && !cap_char_end) char_seen_next = 1'b0;
          if (cap_ceo) begin
            if (word_rise) begin
              word_seen_next = 1'b1;
              push_req       = 1'b1;
              if (cap_error) begin
                push_entry   = {cap_len, cap_dits_dahs, 1'b1, 1'b1};
                rec_cnt_next = '0;
                state_next   = ST_RECOVER;
              end else if (char_rise) begin
                push_entry = {cap_len, cap_dits_dahs, 1'b1, 1'b0};
                state_next = ST_ARM;
              end else begin
                push_entry = {{MORSE_LEN_W{1'b0}}, {MAX_MORSE_LEN{1'b0}}, 1'b1, 1'b0};
                state_next = ST_ARM;
              end
            end else if (char_rise) begin
              push_req       = 1'b1;
              push_entry     = {cap_len, cap_dits_dahs, 1'b0, cap_error};
              char_seen_next = 1'b1;
            end
          end
        end
        ST_RECOVER: begin
          // Re-arm only after a full word time of uninterrupted idle line.
          if (signal) begin
            rec_cnt_next = '0;
          end else if (rec_cnt_inc >= {1'b0, word_time_reg}) begin
            rec_cnt_next = '0;
            state_next   = ST_ARM;
          end else begin
            rec_cnt_next = rec_cnt_inc[PULSE_CNT_W-1:0];
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // FSM registers advance only on tick enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      char_seen_reg  <= 1'b0;
      word_seen_reg  <= 1'b0;
      char_end_d_reg <= 1'b0;
      rec_cnt_reg    <= '0;
    end else if (ce) begin
      state_reg      <= state_next;
      char_seen_reg  <= char_seen_next;
      word_seen_reg  <= word_seen_next;
      char_end_d_reg <= cap_char_end;
      rec_cnt_reg    <= rec_cnt_next;
    end
  end

  // Thresholds are latched once per session in CONFIG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dit_time_reg  <= '0;
      dah_time_reg  <= '0;
      word_time_reg <= '0;
      tol_time_reg  <= '0;
    end else if (ce && cfg_load) begin
      dit_time_reg  <= unit_sel;
      dah_time_reg  <= dah_sat;
      word_time_reg <= word_sat;
      tol_time_reg  <= unit_sel >> 1;
    end
  end

  assign cap_start     = (state_reg == ST_START);
  assign busy          = (state_reg != ST_IDLE);
  assign cap_dit_time  = dit_time_reg;
  assign cap_dah_time  = dah_time_reg;
  assign cap_word_time = word_time_reg;
  assign cap_tol_time  = tol_time_reg;

  // FIFO handshake; a push into a full FIFO survives only if a pop frees a slot
  assign push      = ce & push_req;
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready;
  assign fifo_full = (count_reg == FIFO_FULL_CNT);
  assign push_ok   = push & (~fifo_full | pop);

  // Entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_reg] <= push_entry;
  end

  // FIFO pointers, occupancy and drop accounting; flush wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && !push_ok) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  // Head entry is shown only while valid so an empty FIFO presents zeros
  assign head_entry = out_valid ? mem[rd_ptr_reg] : '0;
  assign {out_len, out_dits_dahs, out_word, out_error} = head_entry;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule
